// File: rtl/muldiv_controller.sv
// -----------------------------------------------------------------------------
// muldiv_controller
//
// Multi-cycle multiply/divide sequencer for the execute stage. It owns the
// architectural HI/LO registers and handles MULT/MULTU/DIV/DIVU/MTHI/MTLO/MF
// requests from the execute datapath.
//
// Parameters:
//   DATA_WIDTH : operand and HI/LO width. A divide runs DATA_WIDTH restoring
//                iterations.
//   MUL_CYCLES : number of clock edges from the accept edge to the HI/LO
//                write for a multiply. Legal range is 1..4.
//
// Optional feature (compile-time macro MULDIV_EARLY_OUT_EN):
//   When the macro is defined, DIV/DIVU skip the iteration phase and go
//   straight from the accept edge to FIX in two cases: |rs| < |rt|, or
//   rt == 0. The result is then available one edge after accept.
//   When the macro is undefined, every divide takes DATA_WIDTH+1 edges.
//
// Ports:
//   clk       in   clock
//   rst_n     in   synchronous active-low reset
//   start     in   request valid this cycle
//   op        in   3'b000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                  101 MTHI, 110 MTLO, 111 MF
//   rs        in   operand A (dividend / multiplicand / MT source)
//   rt        in   operand B (divisor / multiplier)
//   flush     in   abort the in-flight operation
//   stall     out  hold the execute stage
//   busy      out  sequencer is not IDLE
//   done      out  one-cycle pulse after a MUL/DIV writes HI/LO
//   hi        out  HI register
//   lo        out  LO register
//   dbg_state out  current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 FIX)
//
// Request handshake:
//   start is the request valid, and stall acts as an inverted ready. A
//   request is taken on a rising edge where start=1 and stall=0. While stall
//   is high, the requester holds start, op, rs and rt stable. flush has
//   priority over start: a request presented together with flush is
//   dropped.
// -----------------------------------------------------------------------------
module muldiv_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [1:0]            dbg_state
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t            r_state;
    logic [W-1:0]      r_hi;
    logic [W-1:0]      r_lo;
    logic              r_done;
    logic [CW-1:0]     r_cnt;
    logic [W-1:0]      r_a;        // |multiplicand|
    logic [W-1:0]      r_b;        // |multiplier| or |divisor|
    logic [W-1:0]      r_q;        // dividend shifting out, quotient shifting in
    logic [W-1:0]      r_rem;      // partial remainder
    logic              r_qneg;     // sign of the product / quotient
    logic              r_rneg;     // sign of the remainder (sign of rs)
    logic              r_dz;       // divisor was zero
    logic [W-1:0]      r_rs_orig;  // raw rs, returned in HI on divide by zero

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_signed_op;
    logic              w_accept;
    logic              w_mt_hi;
    logic              w_mt_lo;
    logic              w_rs_neg;
    logic              w_rt_neg;
    logic [W-1:0]      w_rs_abs;
    logic [W-1:0]      w_rt_abs;
    logic              w_early;

    assign w_is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_signed_op = (op == OP_MULT) || (op == OP_DIV);

    assign w_accept = (r_state == S_IDLE) && start && !flush && (w_is_mul || w_is_div);
    assign w_mt_hi  = (r_state == S_IDLE) && start && !flush && (op == OP_MTHI);
    assign w_mt_lo  = (r_state == S_IDLE) && start && !flush && (op == OP_MTLO);

    // Magnitudes. Negating the most negative value wraps back to itself. Read
    // as unsigned, that is the correct magnitude, so the signed overflow case
    // needs no special handling.
    assign w_rs_neg = w_signed_op && rs[W-1];
    assign w_rt_neg = w_signed_op && rt[W-1];
    assign w_rs_abs = w_rs_neg ? (~rs + 1'b1) : rs;
    assign w_rt_abs = w_rt_neg ? (~rt + 1'b1) : rt;

`ifdef MULDIV_EARLY_OUT_EN
    // A trivial divide needs no iterations: the quotient is 0 and the
    // remainder is |rs|. Divide by zero is handled in FIX through r_dz.
    assign w_early = w_is_div && ((rt == '0) || (w_rs_abs < w_rt_abs));
`else
    assign w_early = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Restoring divide step: one quotient bit per edge
    // -------------------------------------------------------------------------
    logic [W:0]        w_trial;
    logic [W:0]        w_diff;
    logic              w_qbit;
    logic [W-1:0]      w_rem_next;

    // r_rem is always below the divisor, so the trial value fits in W+1 bits.
    assign w_trial    = {r_rem, r_q[W-1]};
    assign w_diff     = w_trial - {1'b0, r_b};
    assign w_qbit     = ~w_diff[W];
    assign w_rem_next = w_qbit ? w_diff[W-1:0] : w_trial[W-1:0];

    // -------------------------------------------------------------------------
    // Result formation
    // -------------------------------------------------------------------------
    logic [2*W-1:0]    w_prod_mag;
    logic [2*W-1:0]    w_prod;
    logic [W-1:0]      w_quot;
    logic [W-1:0]      w_remv;
    logic [2*W-1:0]    w_div_res;
    logic [2*W-1:0]    w_result;

    assign w_prod_mag = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
    assign w_prod     = r_qneg ? (~w_prod_mag + 1'b1) : w_prod_mag;
    assign w_quot     = r_qneg ? (~r_q + 1'b1)   : r_q;
    assign w_remv     = r_rneg ? (~r_rem + 1'b1) : r_rem;

    // Divide by zero never traps: LO is all ones and HI returns the raw rs.
    assign w_div_res  = r_dz ? {r_rs_orig, {W{1'b1}}} : {w_remv, w_quot};
    assign w_result   = (r_state == S_MUL) ? w_prod : w_div_res;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    state_t            w_next_state;
    logic              w_write_en;
    logic              w_last_mul;
    logic              w_last_div;

    assign w_last_mul = (r_cnt == CW'(MUL_CYCLES - 1));
    assign w_last_div = (r_cnt == CW'(DATA_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and HI/LO write strobe
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_write_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_div) begin
                        w_next_state = w_early ? S_FIX : S_DIV;
                    end else begin
                        w_next_state = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (w_last_mul) begin
                    w_next_state = S_IDLE;
                    w_write_en   = 1'b1;
                end
            end
            S_DIV: begin
                if (w_last_div) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_next_state = S_IDLE;
                w_write_en   = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        // A flush abandons whatever is in flight. This includes a write that
        // would have landed on this same edge.
        if (flush) begin
            w_next_state = S_IDLE;
            w_write_en   = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_dz      <= 1'b0;
            r_rs_orig <= '0;
        end else begin
            r_done <= w_write_en;

            // A result write and an MT write can never coincide. Results are
            // written only when leaving MUL/FIX, and MT writes only in IDLE.
            if (w_write_en) begin
                r_hi <= w_result[2*W-1:W];
                r_lo <= w_result[W-1:0];
            end else begin
                if (w_mt_hi) r_hi <= rs;
                if (w_mt_lo) r_lo <= rs;
            end

            // The counter runs only while the FSM stays in MUL or DIV. Leaving
            // either state (finish, flush) or being elsewhere clears it.
            if ((w_next_state == r_state) &&
                ((r_state == S_MUL) || (r_state == S_DIV))) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (w_accept) begin
                r_a       <= w_rs_abs;
                r_b       <= w_rt_abs;
                r_qneg    <= w_rs_neg ^ w_rt_neg;
                r_rneg    <= w_rs_neg;
                r_dz      <= (rt == '0);
                r_rs_orig <= rs;
                r_q       <= w_early ? '0 : w_rs_abs;
                r_rem     <= w_early ? w_rs_abs : '0;
            end else if (r_state == S_DIV) begin
                r_rem <= w_rem_next;
                r_q   <= {r_q[W-2:0], w_qbit};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy      = (r_state != S_IDLE);
    assign stall     = busy && start && (op != OP_NOP);
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_controller.sv
module tb_muldiv_controller;

    localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int MUL_LAT = 2;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_MF    = 3'b111;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic         flush;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    muldiv_controller #(
        .DATA_WIDTH(W),
        .MUL_CYCLES(MUL_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected {hi,lo}.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h, expected no done", hi, lo);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({hi, lo} !== mon_exp) begin
                    n_errors++;
                    $display("FAIL result: got hi=%h lo=%h, expected hi=%h lo=%h",
                             hi, lo, mon_exp[2*W-1:W], mon_exp[W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request while the DUT is idle. It is taken on the next edge (E0).
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        tick();
        start = 1'b0;
        op    = OP_NOP;
    endtask

    // Count edges after E0 until done rises; the bound counts as a failure.
    task automatic wait_done(input string name, input int exp_lat);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 60 && !seen) begin
            tick();
            cnt++;
            if (done) seen = 1'b1;
        end
        chk({name, "_latency"}, cnt, exp_lat);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e_hi,
                          input logic [W-1:0] e_lo, input int lat);
        exp_q.push_back({e_hi, e_lo});
        issue(o, a, b);
        wait_done(name, lat);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = OP_NOP;
        rs    = '0;
        rt    = '0;
        flush = 1'b0;
        repeat (3) tick();
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();

        // MTHI / MTLO in IDLE: immediate write, no stall
        start = 1'b1; op = OP_MTHI; rs = 32'h0000_1234;
        #1 chk("mthi_stall", stall, 0);
        tick();
        chk("mthi_hi", hi, 32'h0000_1234);
        op = OP_MTLO; rs = 32'h0000_5678;
        tick();
        start = 1'b0; op = OP_NOP;
        chk("mtlo_lo", lo, 32'h0000_5678);
        chk("mt_no_done", done, 0);

        // MULT -3*7 with a queued MF held off by stall
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
        start = 1'b1; op = OP_MULT; rs = 32'hFFFF_FFFD; rt = 32'd7;
        tick();                                  // E0
        op = OP_MF; rs = '0; rt = '0;
        #1;
        chk("mult_busy", busy, 1);
        chk("mf_stall_e0", stall, 1);
        tick();                                  // E1
        chk("mf_stall_e1", stall, 1);
        chk("mult_no_done_e1", done, 0);
        tick();                                  // E2: write
        chk("mult_done", done, 1);
        chk("mf_stall_done_cycle", stall, 0);
        chk("mult_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        start = 1'b0; op = OP_NOP;
        tick();
        chk("mult_done_one_cycle", done, 0);

        // DIVU 100/7 with explicit cycle checks
        exp_q.push_back({32'd2, 32'd14});
        issue(OP_DIVU, 32'd100, 32'd7);          // E0
        repeat (32) tick();                      // E1..E32
        chk("divu_busy_e32", busy, 1);
        chk("divu_state_fix", dbg_state, 3);
        chk("divu_no_done_e32", done, 0);
        tick();                                  // E33
        chk("divu_done_e33", done, 1);
        chk("divu_idle_after", busy, 0);
        tick();

        run_op("div_neg7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("div_by_zero",  OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, EO_LAT);
        run_op("divu_by_zero", OP_DIVU,  32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, EO_LAT);
        run_op("div_overflow", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LAT);
        run_op("divu_small",   OP_DIVU,  32'd3,         32'd10,        32'd3,         32'd0,         EO_LAT);
        run_op("div_small_neg",OP_DIV,   32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD, 32'd0,         EO_LAT);
        run_op("div_7_neg2",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_LAT);
        run_op("divu_max_1",   OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, DIV_LAT);
        run_op("multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        run_op("mult_min_sq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT);

        // MTLO while busy: stalls, then writes on the first IDLE edge
        exp_q.push_back({32'd0, 32'd12});
        issue(OP_MULT, 32'd3, 32'd4);            // E0
        start = 1'b1; op = OP_MTLO; rs = 32'h0000_ABCD;
        #1 chk("mtlo_busy_stall", stall, 1);
        tick();                                  // E1
        tick();                                  // E2: product written
        chk("mtlo_wait_lo", lo, 32'd12);
        tick();                                  // E3: MTLO written
        start = 1'b0; op = OP_NOP;
        chk("mtlo_late_lo", lo, 32'h0000_ABCD);
        chk("mtlo_late_hi", hi, 32'd0);

        // Back-to-back: second multiply accepted in the done cycle
        exp_q.push_back({32'd0, 32'd6});
        exp_q.push_back({32'd0, 32'd1});
        issue(OP_MULTU, 32'd2, 32'd3);           // E0
        start = 1'b1; op = OP_MULT; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
        tick();                                  // E1
        tick();                                  // E2
        chk("b2b_first_done", done, 1);
        tick();                                  // E3: accept
        start = 1'b0; op = OP_NOP;
        chk("b2b_second_busy", busy, 1);
        wait_done("b2b_second", MUL_LAT);
        tick();

        // Flush mid-divide: hi/lo keep their old values, no done
        start = 1'b1; op = OP_MTHI; rs = 32'h0000_AAAA;
        tick();
        op = OP_MTLO; rs = 32'h0000_BBBB;
        tick();
        start = 1'b0; op = OP_NOP;
        issue(OP_DIVU, 32'd100, 32'd7);          // E0
        repeat (10) tick();                      // E1..E10
        flush = 1'b1; start = 1'b1; op = OP_MF;
        #1 chk("flush_cycle_stall", stall, 1);
        tick();                                  // E11
        flush = 1'b0;
        #1;
        chk("flush_busy", busy, 0);
        chk("flush_state", dbg_state, 0);
        chk("flush_stall_after", stall, 0);
        start = 1'b0; op = OP_NOP;
        repeat (40) tick();
        chk("flush_hi", hi, 32'h0000_AAAA);
        chk("flush_lo", lo, 32'h0000_BBBB);

        // Flush on the write edge of a multiply cancels the write
        issue(OP_MULTU, 32'd5, 32'd6);           // E0
        tick();                                  // E1
        flush = 1'b1;
        tick();                                  // E2
        flush = 1'b0;
        chk("flush_wr_busy", busy, 0);
        chk("flush_wr_done", done, 0);
        chk("flush_wr_lo", lo, 32'h0000_BBBB);
        tick();

        // Flush beats start in IDLE
        flush = 1'b1; start = 1'b1; op = OP_MTHI; rs = 32'h0000_DEAD;
        tick();
        chk("flush_idle_mthi", hi, 32'h0000_AAAA);
        op = OP_DIV; rs = 32'd9; rt = 32'd3;
        tick();
        chk("flush_idle_div", busy, 0);
        flush = 1'b0; start = 1'b0; op = OP_NOP;
        tick();

        // Reset mid-divide
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("rst_mid_hi", hi, 0);
        chk("rst_mid_lo", lo, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        rst_n = 1'b1;
        repeat (40) tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
